// File: rtl/mult16_rr_if.sv
// Request/response bundle between client units and mult16_rr_scheduler.
// The req_signed lane exists only when MULT16_RR_SIGNED_EN is defined.
interface mult16_rr_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
`ifdef MULT16_RR_SIGNED_EN
    logic [NREQ-1:0]    req_signed;
`endif
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_product;

    // Client side: raises requests, consumes responses.
    modport master (
        output req_valid, req_a, req_b,
`ifdef MULT16_RR_SIGNED_EN
        output req_signed,
`endif
        output resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b,
`ifdef MULT16_RR_SIGNED_EN
        input  req_signed,
`endif
        input  resp_ready,
        output req_ready, resp_valid, resp_id, resp_product
    );
endinterface

// File: rtl/mult16_rr_scheduler.sv
// Round-robin scheduler sharing one combinational 16x16 multiplier among
// NREQ requesters. Optional two's-complement support via MULT16_RR_SIGNED_EN:
// operands are sent to the multiplier as magnitudes and the product is
// negated on capture when the operand signs differ.
module mult16_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    mult16_rr_if.slave   bus,
    output logic [15:0]  mul_a,
    output logic [15:0]  mul_b,
    input  logic [31:0]  mul_p,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_grant_q;
    logic [15:0]     op_a_q, op_b_q;
    logic [IDW-1:0]  op_id_q;
    logic            op_neg_q;
    logic [IDW-1:0]  resp_id_q;
    logic [31:0]     resp_product_q;

    logic            arb_en;
    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand;
    logic [15:0]     raw_a, raw_b;
    logic [15:0]     win_a, win_b;
    logic            win_neg;
    logic [31:0]     prod_fix;

    // Rotating-priority search starting just after the last granted requester.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        arb_en    = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && bus.resp_ready));
        if (arb_en) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IDW'((int'(last_grant_q) + k) % NREQ);
                if (!grant_vld && bus.req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    // One-hot accept for the winner only.
    always_comb begin
        bus.req_ready = '0;
        if (grant_vld) bus.req_ready[grant_id] = 1'b1;
    end

    // Select the winner's operands; in signed mode convert to magnitudes.
    always_comb begin
        raw_a   = bus.req_a[{grant_id, 4'b0000} +: 16];
        raw_b   = bus.req_b[{grant_id, 4'b0000} +: 16];
        win_a   = raw_a;
        win_b   = raw_b;
        win_neg = 1'b0;
`ifdef MULT16_RR_SIGNED_EN
        if (bus.req_signed[grant_id]) begin
            // -32768 negates to itself, which is the correct 16-bit magnitude.
            if (raw_a[15]) win_a = ~raw_a + 16'd1;
            if (raw_b[15]) win_b = ~raw_b + 16'd1;
            win_neg = raw_a[15] ^ raw_b[15];
        end
`endif
    end

    // Product sign fix-up applied as mul_p is captured.
    always_comb begin
        prod_fix = op_neg_q ? (~mul_p + 32'd1) : mul_p;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = MUL;
            MUL:     state_d = HOLD;
            HOLD:    if (bus.resp_ready) state_d = grant_vld ? MUL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand/grant registers load on transfer; response registers load in MUL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q   <= IDW'(NREQ - 1);
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_id_q        <= '0;
            op_neg_q       <= 1'b0;
            resp_id_q      <= '0;
            resp_product_q <= '0;
        end else begin
            if (grant_vld) begin
                last_grant_q <= grant_id;
                op_a_q       <= win_a;
                op_b_q       <= win_b;
                op_id_q      <= grant_id;
                op_neg_q     <= win_neg;
            end
            if (state_q == MUL) begin
                resp_id_q      <= op_id_q;
                resp_product_q <= prod_fix;
            end
        end
    end

    assign mul_a            = op_a_q;
    assign mul_b            = op_b_q;
    assign bus.resp_valid   = (state_q == HOLD);
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_product = resp_product_q;
    assign busy             = (state_q != IDLE);
endmodule

// File: doc/mult16_rr_scheduler.md
# mult16_rr_scheduler

Round-robin scheduler that shares one combinational 16x16 unsigned multiplier, such as the team's Wallace-tree array, among NREQ requesters. It arbitrates requests, registers the winner's operands onto the multiplier inputs, and captures the product. It returns the product with the requester's index on a single valid/ready response channel. It sits between the client units and the multiplier instance, so the multiplier needs no control logic of its own.

## Interface
- NREQ, default 4: number of requesters; legal range 2..8.
- IDW, default 2: index width, must equal $clog2(NREQ).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*16  operand A; requester i at bits [16i+15:16i].
- req_b  in  NREQ*16  operand B; same packing as req_a.
- req_signed  in  NREQ  two's-complement flag; present only with MULT16_RR_SIGNED_EN.
- mul_a  out  16  operand A to the shared multiplier.
- mul_b  out  16  operand B to the shared multiplier.
- mul_p  in  32  unsigned product from the shared multiplier; combinational from mul_a and mul_b.
- resp_valid  out  1  product available.
- resp_ready  in  1  consumer accepts the product.
- resp_id  out  IDW  index of the requester that owns resp_product.
- resp_product  out  32  result.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM has three states.
  - IDLE: no operation in flight.
  - MUL: operands are on mul_a and mul_b.
  - HOLD: resp_valid is high, waiting for resp_ready.
- Arbitration runs combinationally in IDLE, and in HOLD in the cycle resp_ready is high.
  - The search starts at last_grant+1 (mod NREQ) and takes the first requester with req_valid high.
  - req_ready[w] is high for the winner only, in that same cycle.
  - A request transfers when req_valid[w] and req_ready[w] are both high.
- On transfer:
  - op_a and op_b load the winner's operands, op_id loads w, and last_grant loads w.
  - The FSM goes to MUL.
- MUL:
  - mul_a = op_a and mul_b = op_b.
  - mul_p is captured into resp_product, with sign fix-up when the macro is defined.
  - resp_id = op_id and resp_valid = 1; the FSM goes to HOLD.
  - No request is accepted in MUL.
- HOLD:
  - resp_valid, resp_id and resp_product stay stable until resp_ready is high.
  - On handshake with a pending request: accept it in the same cycle and go to MUL.
  - On handshake with no pending request: go to IDLE.
  - Without handshake: stay in HOLD, and req_ready stays all zero.
- mul_a and mul_b hold op_a and op_b in every state. They change only on a transfer.
- A requester that deasserts req_valid before it is granted is simply skipped; no state is kept for it.
- The arbitration pointer advances only on a transfer.
  - Every requester that holds req_valid high is served within NREQ grants.

## Timing
- Reset values:
  - FSM = IDLE; last_grant = NREQ-1, so requester 0 has first priority.
  - resp_valid = 0, resp_id = 0, resp_product = 0, busy = 0.
  - op_a = 0 and op_b = 0, so mul_a = 0 and mul_b = 0.
  - req_ready is combinational and is 0 while rst_n is low.
- Latency: a request accepted at edge N has resp_valid high after edge N+1.
- Throughput: one product per 2 cycles when resp_ready is held high.
- Simultaneous response handshake and new request in HOLD: both happen in the same cycle. The new product follows two cycles after the previous one.
- Reset mid-operation: the in-flight operation is discarded, no response is produced, and nothing is reported to the requester.
- mul_p must settle within one cycle. Its path is op registers → multiplier → resp_product register.

## Configuration
- MULT16_RR_SIGNED_EN defined:
  - The req_signed port exists, and op_sgn is registered on transfer.
  - With sign = 1:
    - The controller drives the absolute values |a| and |b| on mul_a and mul_b; -32768 maps to 16'h8000.
    - It negates mul_p on capture when a[15]^b[15] is 1.
    - Worst case is -32768*-32768 = 32'h4000_0000.
  - With sign = 0, operands pass through unsigned.
- MULT16_RR_SIGNED_EN undefined: req_signed is absent, and all operands are unsigned with no fix-up logic.

## Test plan
- Requester 0 sends a=16'h00FF, b=16'h0101 with resp_ready held 1 → resp_valid after the second edge, resp_product=32'h0000_FFFF, resp_id=0.
- All four requesters hold req_valid continuously with resp_ready=1 → grant order 0,1,2,3,0. One response every 2 cycles, and each product is correct.
- resp_ready=0 for 5 cycles in HOLD → resp fields stable, req_ready all 0, busy=1. Raising resp_ready with requester 2 pending accepts it in that same cycle.
- Edge operands a=16'hFFFF, b=16'hFFFF → resp_product=32'hFFFE_0001.
- rst_n pulsed low during MUL → resp_valid never rises for that operation, all outputs at reset values, next grant goes to requester 0.
- With MULT16_RR_SIGNED_EN, signed requests:
  - -3*7 → 32'hFFFF_FFEB.
  - -32768*-32768 → 32'h4000_0000.
  - 16'h8000*16'h0002 → 32'hFFFF_0000.
